tick_stamper: RTL and testbench
===============================

Name: tick_stamper

Overview:
- Consumes the one-cycle `tick` pulse from the tick generator and keeps local time as two counters: a seconds count (`sec`) and a sub-tick clock-cycle count (`sub`).
- Timestamps rising edges of an asynchronous external event input with the current {sec, sub} value.
- Buffers timestamps in a small FIFO and presents them on a valid/ready output for a downstream reporter.
- Sits directly downstream of the tick generator, in the PLL clock domain.

Parameters:
- SUB_WIDTH, 27, width of the sub-tick cycle counter; covers 124500000 cycles per tick.
- SEC_WIDTH, 32, width of the tick (seconds) counter.
- DEPTH, 4, number of FIFO entries; must be a power of 2, at least 2.
- SYNC_STAGES, 2, flops in the `event_in` synchronizer; at least 2.

Ports:
- clk  in  1  PLL output clock; all logic on its rising edge.
- rst  in  1  synchronous, active-high reset.
- tick  in  1  one-cycle pulse from the tick generator, synchronous to `clk`.
- event_in  in  1  asynchronous external event; rising edge is timestamped.
- ts_valid  out  1  FIFO non-empty; head entry is on `ts_sec`/`ts_sub`.
- ts_ready  in  1  consumer accepts the head entry when `ts_valid` is also high.
- ts_sec  out  SEC_WIDTH  seconds field of the head entry.
- ts_sub  out  SUB_WIDTH  sub-tick field of the head entry.
- overflow  out  1  sticky flag: at least one timestamp was dropped.
- clr_ovf  in  1  one-cycle clear for `overflow`.

Behaviour:
- Reset, while `rst` is high at a clock edge:
  - `sec`, `sub`, synchronizer flops and edge-history flop go to 0.
  - FIFO is emptied; `ts_valid`=0; `overflow`=0.
  - `ts_sec`/`ts_sub` read 0 while the FIFO is empty.
- Counters, updated every cycle when not in reset:
  - `tick`=1: `sub` <= 0 and `sec` <= `sec`+1, wrapping modulo 2^SEC_WIDTH.
  - Otherwise `sub` <= `sub`+1, saturating at all-ones (missing tick); `sec` holds.
- Event path:
  - `event_in` passes through a SYNC_STAGES flop chain.
  - An edge is detected when the last sync stage is 1 and the edge-history flop is 0.
  - An edge is therefore registered SYNC_STAGES+1 clocks after `event_in` is first sampled high. No latency compensation is applied.
- Capture: in the detection cycle, the current register values {`sec`, `sub`} are pushed. These are the pre-update values.
  - If `tick`=1 in the same cycle, the pre-tick values are captured (old `sec`, full `sub`).
- FIFO:
  - First-word-fall-through; `ts_valid` = not empty.
  - A pushed entry appears on the outputs the cycle after the push when the FIFO was empty.
  - Pop occurs when `ts_valid` and `ts_ready` are both 1; outputs advance to the next entry in the following cycle.
  - Push while full with a simultaneous pop: both occur, no drop.
  - Push while full without a pop: the entry is dropped, FIFO contents are unchanged, and `overflow` <= 1.
  - Push and pop on an empty FIFO: pop is ignored (`ts_valid`=0) and the push is accepted.
- `overflow`:
  - `clr_ovf`=1 clears it.
  - If a drop occurs in the same cycle as `clr_ovf`, `overflow` remains 1.
- `ts_sec`/`ts_sub` are stable while `ts_valid`=1 and `ts_ready`=0.
- Reset mid-operation discards all FIFO entries and any in-flight synchronizer state.
  - If `event_in` is held high across reset release, exactly one capture occurs SYNC_STAGES+1 cycles after release.

Decomposition:
- Package `ticktock_pkg`:
  - TICK_LIMIT (124500000).
  - SUB_WIDTH_DEF = $clog2(TICK_LIMIT).
  - SEC_WIDTH_DEF (32).
  - A packed struct `ts_t` {sec, sub} used as the FIFO word.
- Sub-module `sync_fifo`:
  - Parameterised width/depth, FWFT, push/pop/full/empty.
  - Full-with-pop accepts the push.
- Synchronizer, edge detect, counters and overflow logic stay in `tick_stamper`.

Test Plan:
- Bench parameters are SUB_WIDTH=8, SEC_WIDTH=8, DEPTH=4, with `tick` every 20 cycles.
- Basic capture: reset, then 3 ticks; raise `event_in` 5 cycles after the 3rd tick, with `ts_ready`=1 -> one entry with `ts_sec`=3 and `ts_sub` = 5+SYNC_STAGES+1 (±1 per the sampling alignment, documented in the bench); `overflow`=0.
- Tick coincidence: align edge detection with the cycle carrying the 4th tick -> captured `ts_sec`=3, `ts_sub`=19.
- Overflow: 5 events 30 cycles apart with `ts_ready`=0 -> `ts_valid`=1, 4 entries, `overflow`=1 after the 5th.
  - Then `ts_ready`=1 -> the first 4 timestamps come out in order, then `ts_valid`=0.
  - Then `clr_ovf` pulse -> `overflow`=0.
- Full plus pop: with the FIFO full, assert `ts_ready`=1 in the detection cycle of a new event -> no overflow; the new entry is drained last.
- Missing tick: stop `tick` for 300 cycles -> `sub` reaches 255 and holds; an event then gives `ts_sub`=255.
- Reset mid-operation: 3 entries queued, pulse `rst` -> `ts_valid`=0 and counters 0 after the reset cycle.
  - With `event_in` held high through release -> exactly one entry with `ts_sec`=0, `ts_sub`=SYNC_STAGES.

Source files
------------

// File: rtl/ticktock_pkg.sv
// Shared constants and timestamp word layout for the tick/timestamp blocks.
package ticktock_pkg;

    localparam int unsigned TICK_LIMIT    = 124500000;
    localparam int unsigned SUB_WIDTH_DEF = $clog2(TICK_LIMIT);
    localparam int unsigned SEC_WIDTH_DEF = 32;

    typedef struct packed {
        logic [SEC_WIDTH_DEF-1:0] sec;
        logic [SUB_WIDTH_DEF-1:0] sub;
    } ts_t;

endpackage

// File: rtl/tick_stamper_if.sv
// Valid/ready timestamp stream from the stamper to a downstream reporter.
interface tick_stamper_if import ticktock_pkg::*; #(
    parameter int unsigned SEC_WIDTH = SEC_WIDTH_DEF,
    parameter int unsigned SUB_WIDTH = SUB_WIDTH_DEF
);

    logic                 ts_valid;
    logic                 ts_ready;
    logic [SEC_WIDTH-1:0] ts_sec;
    logic [SUB_WIDTH-1:0] ts_sub;

    modport master (output ts_valid, output ts_sec, output ts_sub, input ts_ready);
    modport slave  (input ts_valid, input ts_sec, input ts_sub, output ts_ready);

endinterface

// File: rtl/tick_stamper_sync_fifo.sv
// First-word-fall-through FIFO; a push into a full FIFO is accepted when a pop happens in the same cycle.
module sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] data_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wr_q, wr_d;
    logic [AW:0]      rd_q, rd_d;
    logic             do_push;
    logic             do_pop;

    // Pointers carry one wrap bit so full and empty are distinguishable.
    always_comb begin
        empty_o = (wr_q == rd_q);
        full_o  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
        do_pop  = pop_i && !empty_o;
        do_push = push_i && (!full_o || do_pop);
        wr_d    = do_push ? wr_q + 1'b1 : wr_q;
        rd_d    = do_pop  ? rd_q + 1'b1 : rd_q;
        data_o  = empty_o ? '0 : mem_q[rd_q[AW-1:0]];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_q <= '0;
            rd_q <= '0;
        end else begin
            wr_q <= wr_d;
            rd_q <= rd_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_q[AW-1:0]] <= data_i;
        end
    end

endmodule

// File: rtl/tick_stamper.sv
// Local {sec, sub} time base driven by tick pulses; timestamps synchronized event_in rising edges into a FIFO.
module tick_stamper import ticktock_pkg::*; #(
    parameter int unsigned SUB_WIDTH   = SUB_WIDTH_DEF,
    parameter int unsigned SEC_WIDTH   = SEC_WIDTH_DEF,
    parameter int unsigned DEPTH       = 4,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           tick,
    input  logic           event_in,
    input  logic           clr_ovf,
    output logic           overflow,
    tick_stamper_if.master ts
);

    typedef struct packed {
        logic [SEC_WIDTH-1:0] sec;
        logic [SUB_WIDTH-1:0] sub;
    } stamp_t;

    logic [SEC_WIDTH-1:0]   sec_q, sec_d;
    logic [SUB_WIDTH-1:0]   sub_q, sub_d;
    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   edge_q;
    logic                   ovf_q, ovf_d;
    logic                   ev_edge;
    logic                   pop;
    logic                   drop;
    logic                   fifo_full;
    logic                   fifo_empty;
    stamp_t                 push_word;
    stamp_t                 head_word;

    // The captured word is the pre-update counter value, so a coincident tick stamps the old second.
    always_comb begin
        sync_d    = {sync_q[SYNC_STAGES-2:0], event_in};
        ev_edge   = sync_q[SYNC_STAGES-1] & ~edge_q;
        pop       = ts.ts_ready & ~fifo_empty;
        drop      = ev_edge & fifo_full & ~pop;
        push_word = '{sec: sec_q, sub: sub_q};

        sec_d = sec_q;
        sub_d = sub_q;
        if (tick) begin
            sub_d = '0;
            sec_d = sec_q + 1'b1;
        end else if (sub_q != '1) begin
            sub_d = sub_q + 1'b1;
        end

        ovf_d = ovf_q;
        if (drop) begin
            ovf_d = 1'b1;
        end else if (clr_ovf) begin
            ovf_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sec_q  <= '0;
            sub_q  <= '0;
            sync_q <= '0;
            edge_q <= 1'b0;
            ovf_q  <= 1'b0;
        end else begin
            sec_q  <= sec_d;
            sub_q  <= sub_d;
            sync_q <= sync_d;
            edge_q <= sync_q[SYNC_STAGES-1];
            ovf_q  <= ovf_d;
        end
    end

    sync_fifo #(
        .WIDTH ($bits(stamp_t)),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (ev_edge),
        .data_i  (push_word),
        .pop_i   (ts.ts_ready),
        .data_o  (head_word),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    assign ts.ts_valid = ~fifo_empty;
    assign ts.ts_sec   = head_word.sec;
    assign ts.ts_sub   = head_word.sub;
    assign overflow    = ovf_q;

endmodule

// File: tb/tb_tick_stamper.sv
// Self-checking bench for tick_stamper: directed vectors, corner sequences and random traffic against a queue model.
module tb_tick_stamper;

    localparam int unsigned SUBW        = 8;
    localparam int unsigned SECW        = 8;
    localparam int unsigned DEPTH       = 4;
    localparam int unsigned SYNC        = 2;
    localparam int unsigned TICK_PERIOD = 20;
    localparam int unsigned SEC_MOD     = 1 << SECW;
    localparam int unsigned SUB_MAX     = (1 << SUBW) - 1;

    logic clk      = 1'b0;
    logic rst      = 1'b1;
    logic tick     = 1'b0;
    logic event_in = 1'b0;
    logic clr_ovf  = 1'b0;
    logic ready    = 1'b0;
    logic overflow;

    tick_stamper_if #(.SEC_WIDTH(SECW), .SUB_WIDTH(SUBW)) ts_bus ();
    assign ts_bus.ts_ready = ready;

    tick_stamper #(
        .SUB_WIDTH   (SUBW),
        .SEC_WIDTH   (SECW),
        .DEPTH       (DEPTH),
        .SYNC_STAGES (SYNC)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .tick     (tick),
        .event_in (event_in),
        .clr_ovf  (clr_ovf),
        .overflow (overflow),
        .ts       (ts_bus)
    );

    always #5 clk = ~clk;

    // Reference model: time base as plain integers, event samples as a delay line, FIFO as a queue.
    typedef struct {
        int unsigned sec;
        int unsigned sub;
    } stamp_t;

    stamp_t      m_q[$];
    int unsigned m_sec = 0;
    int unsigned m_sub = 0;
    bit          m_ovf = 0;
    bit          hist [SYNC+1];

    always @(posedge clk) begin : ref_model
        bit     det;
        bit     dropped;
        stamp_t s;
        if (rst) begin
            m_sec = 0;
            m_sub = 0;
            m_ovf = 0;
            m_q.delete();
            for (int i = 0; i <= SYNC; i++) hist[i] = 0;
        end else begin
            // hist[k] is the event_in sample taken k+1 edges ago.
            det     = hist[SYNC-1] && !hist[SYNC];
            dropped = 0;
            if (m_q.size() != 0 && ready) void'(m_q.pop_front());
            if (det) begin
                if (m_q.size() < DEPTH) begin
                    s.sec = m_sec;
                    s.sub = m_sub;
                    m_q.push_back(s);
                end else begin
                    dropped = 1;
                end
            end
            if (dropped) m_ovf = 1;
            else if (clr_ovf) m_ovf = 0;
            for (int i = SYNC; i > 0; i--) hist[i] = hist[i-1];
            hist[0] = event_in;
            if (tick) begin
                m_sub = 0;
                m_sec = (m_sec + 1) % SEC_MOD;
            end else if (m_sub < SUB_MAX) begin
                m_sub = m_sub + 1;
            end
        end
    end

    int unsigned checks   = 0;
    int unsigned failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    task automatic sb_check();
        chk("sb_valid", 32'(ts_bus.ts_valid), 32'(m_q.size() != 0));
        chk("sb_overflow", 32'(overflow), 32'(m_ovf));
        if (m_q.size() != 0) begin
            chk("sb_sec", 32'(ts_bus.ts_sec), m_q[0].sec);
            chk("sb_sub", 32'(ts_bus.ts_sub), m_q[0].sub);
        end else begin
            chk("sb_sec_empty", 32'(ts_bus.ts_sec), 32'd0);
            chk("sb_sub_empty", 32'(ts_bus.ts_sub), 32'd0);
        end
    endtask

    int unsigned phase      = 0;
    int unsigned ticks_seen = 0;
    bit          tick_en    = 1;

    // One clock: sample #1 after the edge, then set up tick for the next edge.
    task automatic step();
        @(posedge clk);
        #1;
        sb_check();
        if (tick) ticks_seen++;
        if (tick_en) begin
            phase = (phase + 1) % TICK_PERIOD;
            tick  = (phase == TICK_PERIOD - 1);
        end else begin
            tick = 1'b0;
        end
    endtask

    task automatic do_reset();
        rst  = 1'b1;
        tick = 1'b0;
        step();
        rst        = 1'b0;
        tick       = 1'b0;
        phase      = 0;
        ticks_seen = 0;
    endtask

    task automatic wait_ticks(input int unsigned n);
        for (int i = 0; i < (n + 1) * TICK_PERIOD && ticks_seen < n; i++) step();
    endtask

    task automatic wait_valid(input int unsigned max, output int unsigned n);
        n = 0;
        while (!ts_bus.ts_valid && n < max) begin
            step();
            n++;
        end
        chk("valid_timeout", 32'(ts_bus.ts_valid), 32'd1);
    endtask

    task automatic pulse_events(input int unsigned count);
        for (int e = 0; e < count; e++) begin
            event_in = 1'b1;
            repeat (3) step();
            event_in = 1'b0;
            repeat (27) step();
        end
    endtask

    task automatic drain_count(output int unsigned n);
        ready = 1'b1;
        n     = 0;
        while (ts_bus.ts_valid && n < 20) begin
            step();
            n++;
        end
        ready = 1'b0;
    endtask

    typedef struct {
        int unsigned ticks;
        int unsigned delay;
        int unsigned exp_sec;
        int unsigned exp_sub;
    } vec_t;

    vec_t vecs[5];

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        int unsigned n;
        // event_in is raised after edge T+delay (sub=delay), first sampled at T+delay+1, and the
        // detection cycle follows SYNC_STAGES-1 edges later, so ts_sub = delay + SYNC_STAGES.
        vecs[0] = '{3, 5,  3, 5 + SYNC};
        vecs[1] = '{3, 17, 3, 19};
        vecs[2] = '{1, 0,  1, SYNC};
        vecs[3] = '{2, 10, 2, 10 + SYNC};
        vecs[4] = '{4, 12, 4, 12 + SYNC};

        do_reset();
        chk("reset_valid", 32'(ts_bus.ts_valid), 32'd0);
        chk("reset_overflow", 32'(overflow), 32'd0);

        for (int i = 0; i < 5; i++) begin
            vec_t v;
            v = vecs[i];
            do_reset();
            ready = 1'b0;
            wait_ticks(v.ticks);
            repeat (v.delay) step();
            event_in = 1'b1;
            wait_valid(SYNC + 3, n);
            chk($sformatf("vec%0d_sec", i), 32'(ts_bus.ts_sec), v.exp_sec);
            chk($sformatf("vec%0d_sub", i), 32'(ts_bus.ts_sub), v.exp_sub);
            chk($sformatf("vec%0d_ovf", i), 32'(overflow), 32'd0);
            event_in = 1'b0;
            ready    = 1'b1;
            step();
            ready = 1'b0;
            chk($sformatf("vec%0d_drained", i), 32'(ts_bus.ts_valid), 32'd0);
        end

        // Overflow: five events into a four-entry FIFO with no consumer.
        do_reset();
        pulse_events(5);
        chk("ovf_valid", 32'(ts_bus.ts_valid), 32'd1);
        chk("ovf_flag", 32'(overflow), 32'd1);
        drain_count(n);
        chk("ovf_drained", n, 32'd4);
        chk("ovf_empty", 32'(ts_bus.ts_valid), 32'd0);
        chk("ovf_still_set", 32'(overflow), 32'd1);
        clr_ovf = 1'b1;
        step();
        clr_ovf = 1'b0;
        chk("ovf_cleared", 32'(overflow), 32'd0);

        // Full FIFO with a pop landing on the detection edge of a new event.
        pulse_events(4);
        chk("full_valid", 32'(ts_bus.ts_valid), 32'd1);
        event_in = 1'b1;
        repeat (SYNC) step();
        ready = 1'b1;
        step();
        ready    = 1'b0;
        event_in = 1'b0;
        repeat (3) step();
        chk("fullpop_ovf", 32'(overflow), 32'd0);
        drain_count(n);
        chk("fullpop_drained", n, 32'd4);

        // Missing tick: sub saturates at all-ones.
        do_reset();
        tick_en = 0;
        tick    = 1'b0;
        repeat (300) step();
        event_in = 1'b1;
        wait_valid(SYNC + 3, n);
        chk("miss_sub", 32'(ts_bus.ts_sub), SUB_MAX);
        chk("miss_sec", 32'(ts_bus.ts_sec), 32'd0);
        event_in = 1'b0;
        ready    = 1'b1;
        step();
        ready   = 1'b0;
        tick_en = 1;

        // Reset mid-operation with event_in held high through release.
        do_reset();
        pulse_events(3);
        chk("pre_rst_valid", 32'(ts_bus.ts_valid), 32'd1);
        event_in = 1'b1;
        do_reset();
        chk("rst_valid", 32'(ts_bus.ts_valid), 32'd0);
        chk("rst_ovf", 32'(overflow), 32'd0);
        wait_valid(SYNC + 4, n);
        chk("rst_latency", n, SYNC + 1);
        chk("rst_sec", 32'(ts_bus.ts_sec), 32'd0);
        chk("rst_sub", 32'(ts_bus.ts_sub), SYNC);
        ready = 1'b1;
        step();
        ready = 1'b0;
        repeat (10) step();
        chk("rst_single", 32'(ts_bus.ts_valid), 32'd0);
        event_in = 1'b0;

        // Random traffic against the reference model.
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 3) == 0) event_in = ~event_in;
            ready   = ($urandom_range(0, 2) == 0);
            clr_ovf = ($urandom_range(0, 30) == 0);
            rst     = ($urandom_range(0, 499) == 0);
            if ($urandom_range(0, 199) == 0) tick_en = !tick_en;
            step();
        end
        rst     = 1'b0;
        ready   = 1'b0;
        clr_ovf = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
